// File: rtl/wb_mailbox_pkg.sv
// Shared register map, field positions and reset constants for the
// Wishbone mailbox bridge and its sub-blocks.
package wb_mailbox_pkg;

    // Word offsets (address bits [7:2]) of the mailbox registers
    localparam logic [5:0] OFF_CTRL     = 6'h00;
    localparam logic [5:0] OFF_STATUS   = 6'h01;
    localparam logic [5:0] OFF_H2C_DATA = 6'h02;
    localparam logic [5:0] OFF_C2H_DATA = 6'h03;
    localparam logic [5:0] OFF_OEB_LO   = 6'h04;
    localparam logic [5:0] OFF_OEB_HI   = 6'h05;

    // CTRL field positions
    localparam int CTRL_CORE_RST_BIT = 0;
    localparam int CTRL_FLUSH_BIT    = 1;
    localparam int CTRL_IRQ_EN_LSB   = 4;

    // STATUS field positions
    localparam int ST_FULL_BIT     = 0;
    localparam int ST_EMPTY_BIT    = 1;
    localparam int ST_C2H_FULL_BIT = 2;
    localparam int ST_OVF_BIT      = 3;
    localparam int ST_COUNT_LSB    = 8;

    // CTRL comes out of reset with the core held in reset
    localparam logic [31:0] CTRL_RST_VAL = 32'h0000_0001;

    // Stored (non self-clearing) part of CTRL
    typedef struct packed {
        logic [2:0] irq_en;
        logic       core_rst;
    } ctrl_t;

    // Byte-lane merge of a write into a 32-bit register
    function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  sel);
        logic [31:0] res;
        res = old_v;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) begin
                res[b*8 +: 8] = new_v[b*8 +: 8];
            end else begin
                res[b*8 +: 8] = old_v[b*8 +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/wb_mailbox_bridge_if.sv
// Wishbone classic slave bus bundle used between host and mailbox bridge.
interface wb_mailbox_bridge_if;
    logic        wbs_cyc_i;
    logic        wbs_stb_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    modport master (
        output wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o
    );

    modport slave (
        input  wbs_cyc_i, wbs_stb_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o
    );
endinterface

// File: rtl/wb_mbox_fifo.sv
// Synchronous FIFO with flush; a push while full is accepted only when a
// pop happens on the same edge, otherwise the word is dropped.
module wb_mbox_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [W-1:0]             data_i,
    output logic [W-1:0]             data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push_s, do_pop_s, do_write_s;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == {CW{1'b0}});
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // Next pointer/count; flush overrides any push or pop on the same edge
    always_comb begin
        do_pop_s   = pop_i & ~empty_o;
        do_push_s  = push_i & (~full_o | do_pop_s);
        do_write_s = do_push_s & ~flush_i;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (flush_i) begin
            wr_ptr_d = {AW{1'b0}};
            rd_ptr_d = {AW{1'b0}};
            count_d  = {CW{1'b0}};
        end else begin
            if (do_push_s) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (do_pop_s) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {AW{1'b0}};
            rd_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while the pointers say empty
    always_ff @(posedge clk_i) begin
        if (do_write_s && !rst_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/wb_mailbox_bridge.sv
// Wishbone register block giving the host a mailbox to the darksocv core:
// host-to-core FIFO, single-word core-to-host slot, interrupts, pad OEB.
module wb_mailbox_bridge
    import wb_mailbox_pkg::*;
#(
    parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          IO_W       = 38
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    wb_mailbox_bridge_if.slave    wbs,
    output logic                  core_rst_o,
    output logic                  h2c_valid_o,
    output logic [31:0]           h2c_data_o,
    input  logic                  h2c_ready_i,
    input  logic                  c2h_valid_i,
    input  logic [31:0]           c2h_data_i,
    output logic                  c2h_ready_o,
    output logic [2:0]            user_irq_o,
    output logic [IO_W-1:0]       io_oeb_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            req_s;
    logic [5:0]      off_s;
    logic            push_s, pop_s, flush_s, ovf_clr_s;
    logic            fifo_full_s, fifo_empty_s;
    logic [CW-1:0]   fifo_count_s;
    logic [1:0]      unused_adr_s;

    logic            ack_q;
    logic [31:0]     rdata_q, rdata_d;
    ctrl_t           ctrl_q, ctrl_d;
    logic            ovf_q, ovf_d;
    logic            c2h_full_q, c2h_full_d;
    logic [31:0]     c2h_data_q, c2h_data_d;
    logic [2:0]      irq_q, irq_d;
    logic [IO_W-1:0] oeb_q, oeb_d;

    assign req_s = wbs.wbs_cyc_i & wbs.wbs_stb_i &
                   (wbs.wbs_adr_i[31:8] == BASE_ADR[31:8]) & ~ack_q;
    assign off_s        = wbs.wbs_adr_i[7:2];
    assign unused_adr_s = wbs.wbs_adr_i[1:0];
    assign pop_s        = ~fifo_empty_s & h2c_ready_i;

    assign wbs.wbs_ack_o = ack_q;
    assign wbs.wbs_dat_o = rdata_q;
    assign core_rst_o    = ctrl_q.core_rst | wb_rst_i;
    assign h2c_valid_o   = ~fifo_empty_s;
    assign c2h_ready_o   = ~c2h_full_q;
    assign user_irq_o    = irq_q;
    assign io_oeb_o      = oeb_q;

    wb_mbox_fifo #(
        .W     (32),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .flush_i (flush_s),
        .data_i  (wbs.wbs_dat_i),
        .data_o  (h2c_data_o),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    // Register decode, read mux and next-state of all mailbox state
    always_comb begin
        rdata_d    = 32'h0;
        ctrl_d     = ctrl_q;
        ovf_d      = ovf_q;
        c2h_full_d = c2h_full_q;
        c2h_data_d = c2h_data_q;
        oeb_d      = oeb_q;
        push_s     = 1'b0;
        flush_s    = 1'b0;
        ovf_clr_s  = 1'b0;

        // Core-side capture into the empty slot
        if (c2h_valid_i && !c2h_full_q) begin
            c2h_full_d = 1'b1;
            c2h_data_d = c2h_data_i;
        end else begin
            c2h_data_d = c2h_data_q;
        end

        if (req_s && wbs.wbs_we_i) begin
            case (off_s)
                OFF_CTRL: begin
                    if (wbs.wbs_sel_i[0]) begin
                        ctrl_d.core_rst = wbs.wbs_dat_i[CTRL_CORE_RST_BIT];
                        ctrl_d.irq_en   = wbs.wbs_dat_i[CTRL_IRQ_EN_LSB +: 3];
                        flush_s         = wbs.wbs_dat_i[CTRL_FLUSH_BIT];
                    end else begin
                        ctrl_d = ctrl_q;
                    end
                end
                OFF_STATUS: begin
                    ovf_clr_s = wbs.wbs_sel_i[0] & wbs.wbs_dat_i[ST_OVF_BIT];
                end
                OFF_H2C_DATA: begin
                    push_s = (wbs.wbs_sel_i == 4'hF);
                end
                OFF_OEB_LO: begin
                    oeb_d[31:0] = byte_merge(oeb_q[31:0], wbs.wbs_dat_i, wbs.wbs_sel_i);
                end
                OFF_OEB_HI: begin
                    for (int i = 32; i < IO_W; i++) begin
                        if (wbs.wbs_sel_i[(i-32)/8]) begin
                            oeb_d[i] = wbs.wbs_dat_i[i-32];
                        end else begin
                            oeb_d[i] = oeb_q[i];
                        end
                    end
                end
                default: begin
                    rdata_d = 32'h0;
                end
            endcase
        end else if (req_s) begin
            case (off_s)
                OFF_CTRL: begin
                    rdata_d[CTRL_CORE_RST_BIT]    = ctrl_q.core_rst;
                    rdata_d[CTRL_IRQ_EN_LSB +: 3] = ctrl_q.irq_en;
                end
                OFF_STATUS: begin
                    rdata_d[ST_FULL_BIT]          = fifo_full_s;
                    rdata_d[ST_EMPTY_BIT]         = fifo_empty_s;
                    rdata_d[ST_C2H_FULL_BIT]      = c2h_full_q;
                    rdata_d[ST_OVF_BIT]           = ovf_q;
                    rdata_d[ST_COUNT_LSB +: CW]   = fifo_count_s;
                end
                OFF_C2H_DATA: begin
                    if (c2h_full_q) begin
                        rdata_d    = c2h_data_q;
                        c2h_full_d = 1'b0;
                    end else begin
                        rdata_d    = 32'h0;
                    end
                end
                OFF_OEB_LO: begin
                    rdata_d = oeb_q[31:0];
                end
                OFF_OEB_HI: begin
                    rdata_d[IO_W-33:0] = oeb_q[IO_W-1:32];
                end
                default: begin
                    rdata_d = 32'h0;
                end
            endcase
        end else begin
            rdata_d = 32'h0;
        end

        // A dropped push sets the sticky flag; that beats a same-cycle clear
        if (push_s && fifo_full_s && !pop_s && !flush_s) begin
            ovf_d = 1'b1;
        end else if (ovf_clr_s) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end

        irq_d = {ctrl_q.irq_en[2] & ovf_q,
                 ctrl_q.irq_en[1] & fifo_empty_s,
                 ctrl_q.irq_en[0] & c2h_full_q};
    end

    // Bus handshake and register state; reset discards an in-flight access
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ack_q      <= 1'b0;
            rdata_q    <= 32'h0;
            ctrl_q     <= ctrl_t'({CTRL_RST_VAL[6:4], CTRL_RST_VAL[0]});
            ovf_q      <= 1'b0;
            c2h_full_q <= 1'b0;
            c2h_data_q <= 32'h0;
            irq_q      <= 3'b000;
            oeb_q      <= {IO_W{1'b1}};
        end else begin
            ack_q      <= req_s;
            rdata_q    <= rdata_d;
            ctrl_q     <= ctrl_d;
            ovf_q      <= ovf_d;
            c2h_full_q <= c2h_full_d;
            c2h_data_q <= c2h_data_d;
            irq_q      <= irq_d;
            oeb_q      <= oeb_d;
        end
    end

endmodule

// File: tb/tb_wb_mailbox_bridge.sv
// Directed self-checking bench for the Wishbone mailbox bridge.
module tb_wb_mailbox_bridge;
    import wb_mailbox_pkg::*;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_rst;
    logic        h2c_valid;
    logic [31:0] h2c_data;
    logic        h2c_ready = 1'b0;
    logic        c2h_valid = 1'b0;
    logic [31:0] c2h_data  = 32'h0;
    logic        c2h_ready;
    logic [2:0]  irq;
    logic [37:0] oeb;

    int checks = 0;
    int errors = 0;

    wb_mailbox_bridge_if bus();

    wb_mailbox_bridge #(.BASE_ADR(BASE), .FIFO_DEPTH(4), .IO_W(38)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .wbs         (bus),
        .core_rst_o  (core_rst),
        .h2c_valid_o (h2c_valid),
        .h2c_data_o  (h2c_data),
        .h2c_ready_i (h2c_ready),
        .c2h_valid_i (c2h_valid),
        .c2h_data_i  (c2h_data),
        .c2h_ready_o (c2h_ready),
        .user_irq_o  (irq),
        .io_oeb_o    (oeb)
    );

    always #5 clk = ~clk;

    // One bus access; returns read data and whether ack came within 4 cycles
    task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic pop,
                           output logic [31:0] rd, output logic acked);
        @(negedge clk);
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = we;
        bus.wbs_adr_i = adr;  bus.wbs_dat_i = dat;  bus.wbs_sel_i = sel;
        h2c_ready = pop;
        acked = 1'b0;
        rd = 32'h0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(posedge clk); #1;
            h2c_ready = 1'b0;
            if (bus.wbs_ack_o === 1'b1) begin
                acked = 1'b1;
                rd = bus.wbs_dat_o;
            end
        end
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] rd; logic ok;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.wbs_ack_o !== 1'b0 || bus.wbs_dat_o !== 32'h0) begin errors++; $display("FAIL rst_bus ack=%b dat=%h exp 0/0", bus.wbs_ack_o, bus.wbs_dat_o); end
        checks++; if (core_rst !== 1'b1 || irq !== 3'b000) begin errors++; $display("FAIL rst_out core_rst=%b irq=%b exp 1/000", core_rst, irq); end
        checks++; if (oeb !== {38{1'b1}} || h2c_valid !== 1'b0 || c2h_ready !== 1'b1) begin errors++; $display("FAIL rst_io oeb=%h h2c_valid=%b c2h_ready=%b", oeb, h2c_valid, c2h_ready); end
        rst = 1'b0;
        wb_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (!ok || rd !== 32'h1 || core_rst !== 1'b1) begin errors++; $display("FAIL ctrl_rst_read got %h ack=%b core_rst=%b exp 00000001", rd, ok, core_rst); end
        wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (!ok || rd !== 32'h0000_0002) begin errors++; $display("FAIL status_rst got %h exp 00000002", rd); end
        wb_xfer(1'b1, BASE + 32'h00, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (!ok || core_rst !== 1'b0) begin errors++; $display("FAIL ctrl_release core_rst=%b ack=%b exp 0", core_rst, ok); end
    endtask

    task automatic test_fifo_overflow();
        logic [31:0] rd; logic ok;
        for (int k = 0; k < 4; k++) wb_xfer(1'b1, BASE + 32'h08, 32'hA0 + k, 4'hF, 1'b0, rd, ok);
        wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (rd !== 32'h0000_0401) begin errors++; $display("FAIL status_full got %h exp 00000401", rd); end
        wb_xfer(1'b1, BASE + 32'h08, 32'hFF, 4'hF, 1'b0, rd, ok);
        wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (rd !== 32'h0000_0409) begin errors++; $display("FAIL status_ovf got %h exp 00000409", rd); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (h2c_valid !== 1'b1 || h2c_data !== 32'hA0 + k) begin errors++; $display("FAIL pop_order[%0d] got %h valid=%b exp %h", k, h2c_data, h2c_valid, 32'hA0 + k); end
            h2c_ready = 1'b1;
        end
        @(negedge clk); h2c_ready = 1'b0;
        checks++; if (h2c_valid !== 1'b0) begin errors++; $display("FAIL pop_empty valid=%b exp 0", h2c_valid); end
        wb_xfer(1'b1, BASE + 32'h04, 32'h8, 4'h1, 1'b0, rd, ok);
        wb_xfer(1'b1, BASE + 32'h08, 32'h55, 4'h7, 1'b0, rd, ok);
        wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (rd !== 32'h0000_0002) begin errors++; $display("FAIL ovf_clr_partial_push got %h exp 00000002", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic ok;
        for (int k = 0; k < 4; k++) wb_xfer(1'b1, BASE + 32'h08, 32'h10 + k, 4'hF, 1'b0, rd, ok);
        wb_xfer(1'b1, BASE + 32'h08, 32'hB0, 4'hF, 1'b1, rd, ok);
        wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (rd !== 32'h0000_0401) begin errors++; $display("FAIL push_pop_full got %h exp 00000401", rd); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (h2c_data !== ((k == 3) ? 32'hB0 : 32'h11 + k)) begin errors++; $display("FAIL tail_order[%0d] got %h", k, h2c_data); end
            h2c_ready = 1'b1;
        end
        @(negedge clk); h2c_ready = 1'b0;
    endtask

    task automatic test_c2h();
        logic [31:0] rd; logic ok;
        wb_xfer(1'b1, BASE + 32'h00, 32'h10, 4'hF, 1'b0, rd, ok);
        @(negedge clk);
        c2h_valid = 1'b1; c2h_data = 32'h1234_5678;
        @(negedge clk);
        c2h_valid = 1'b0;
        checks++; if (c2h_ready !== 1'b0) begin errors++; $display("FAIL c2h_ready_full got %b exp 0", c2h_ready); end
        @(negedge clk);
        checks++; if (irq !== 3'b001) begin errors++; $display("FAIL irq_c2h got %b exp 001", irq); end
        wb_xfer(1'b0, BASE + 32'h0C, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (!ok || rd !== 32'h1234_5678 || c2h_ready !== 1'b1) begin errors++; $display("FAIL c2h_read got %h ready=%b exp 12345678/1", rd, c2h_ready); end
        @(posedge clk); #1;
        checks++; if (irq !== 3'b000) begin errors++; $display("FAIL irq_clear got %b exp 000", irq); end
        wb_xfer(1'b0, BASE + 32'h0C, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (!ok || rd !== 32'h0) begin errors++; $display("FAIL c2h_read_empty got %h exp 0", rd); end
        wb_xfer(1'b1, BASE + 32'h00, 32'h20, 4'hF, 1'b0, rd, ok);
        @(posedge clk); #1;
        checks++; if (irq !== 3'b010) begin errors++; $display("FAIL irq_empty got %b exp 010", irq); end
        wb_xfer(1'b1, BASE + 32'h00, 32'h0, 4'hF, 1'b0, rd, ok);
    endtask

    task automatic test_oeb_unmapped();
        logic [31:0] rd; logic ok;
        wb_xfer(1'b1, BASE + 32'h10, 32'h0, 4'b0001, 1'b0, rd, ok);
        checks++; if (oeb !== 38'h3F_FFFF_FF00) begin errors++; $display("FAIL oeb_lo_byte got %h exp 3fffffff00", oeb); end
        wb_xfer(1'b0, BASE + 32'h14, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (!ok || rd !== 32'h3F) begin errors++; $display("FAIL oeb_hi_read got %h exp 0000003f", rd); end
        wb_xfer(1'b1, BASE + 32'h14, 32'h0, 4'b0001, 1'b0, rd, ok);
        checks++; if (oeb !== 38'h00_FFFF_FF00) begin errors++; $display("FAIL oeb_hi_write got %h exp 00ffffff00", oeb); end
        wb_xfer(1'b1, BASE + 32'h3C, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, ok);
        wb_xfer(1'b0, BASE + 32'h3C, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (!ok || rd !== 32'h0) begin errors++; $display("FAIL unmapped got %h ack=%b exp 0/1", rd, ok); end
        wb_xfer(1'b0, BASE + 32'h100, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (ok !== 1'b0) begin errors++; $display("FAIL off_base_ack got %b exp 0", ok); end
    endtask

    task automatic test_flush();
        logic [31:0] rd; logic ok;
        for (int k = 0; k < 3; k++) wb_xfer(1'b1, BASE + 32'h08, 32'hC0 + k, 4'hF, 1'b0, rd, ok);
        wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (rd !== 32'h0000_0300) begin errors++; $display("FAIL status_three got %h exp 00000300", rd); end
        wb_xfer(1'b1, BASE + 32'h00, 32'h2, 4'hF, 1'b1, rd, ok);
        wb_xfer(1'b0, BASE + 32'h04, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (rd !== 32'h0000_0002 || h2c_valid !== 1'b0) begin errors++; $display("FAIL flush got %h valid=%b exp 00000002/0", rd, h2c_valid); end
        wb_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (rd !== 32'h0) begin errors++; $display("FAIL flush_selfclear got %h exp 0", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic ok;
        @(negedge clk);
        rst = 1'b1;
        bus.wbs_cyc_i = 1'b1; bus.wbs_stb_i = 1'b1; bus.wbs_we_i = 1'b1;
        bus.wbs_adr_i = BASE + 32'h10; bus.wbs_dat_i = 32'h0; bus.wbs_sel_i = 4'hF;
        @(posedge clk); #1;
        checks++; if (bus.wbs_ack_o !== 1'b0 || oeb !== {38{1'b1}} || core_rst !== 1'b1) begin errors++; $display("FAIL rst_mid ack=%b oeb=%h core_rst=%b", bus.wbs_ack_o, oeb, core_rst); end
        @(negedge clk);
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        rst = 1'b0;
        wb_xfer(1'b0, BASE + 32'h00, 32'h0, 4'hF, 1'b0, rd, ok);
        checks++; if (!ok || rd !== 32'h1) begin errors++; $display("FAIL rst_mid_ctrl got %h exp 00000001", rd); end
    endtask

    initial begin
        bus.wbs_cyc_i = 1'b0; bus.wbs_stb_i = 1'b0; bus.wbs_we_i = 1'b0;
        bus.wbs_sel_i = 4'h0; bus.wbs_adr_i = 32'h0; bus.wbs_dat_i = 32'h0;
        test_reset();
        test_fifo_overflow();
        test_back_to_back();
        test_c2h();
        test_oeb_unmapped();
        test_flush();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
